data_rate_decoder: RTL and testbench
====================================

Name: data_rate_decoder

Overview:
- Receive-side counterpart of the backscatter data-rate bit generator.
- Recovers a frame from a serial bitstream in which each bit is held for BIT_PERIOD clocks while the link is enabled.
- Frame format: one marker byte 0x80 (a 1 followed by seven 0s), then PAYLOAD_BYTES payload bytes, MSB first.
- Delivers payload bytes with a one-cycle valid strobe and flags the end of the frame; sits between the demodulator/comparator output and the packet logic.

Parameters:
- BIT_PERIOD, 50, clocks per bit (min 4, max 65535).
- PAYLOAD_BYTES, 49, payload bytes per frame after the marker byte (min 1, max 255).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  link active; low forces IDLE
- rx_in  input  1  raw serial bit, asynchronous to clock
- data_out  output  8  last received payload byte
- data_valid  output  1  one-cycle strobe, data_out new
- frame_done  output  1  one-cycle strobe, last payload byte of frame
- header_error  output  1  one-cycle strobe, marker byte malformed
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; state IDLE.
  - Synchronizer flops 0; bit, byte and clock counters 0.
- Input synchronizer:
  - rx_in passes through a 2-flop synchronizer to give rx_s.
  - A third flop holds rx_d (previous rx_s). Rising edge = rx_s & ~rx_d.
- Clock counter cnt, 16 bits. bit_cnt, 3 bits. byte_cnt, 8 bits.
- enable low, in any state:
  - Next cycle: state IDLE, counters cleared, strobes 0.
  - data_out holds its value. No frame_done or header_error is issued.
- State IDLE:
  - On rising edge with enable=1: cnt<=0, go to MARK.
- State MARK (mid-bit confirm of the marker 1):
  - cnt increments each clock.
  - When cnt==BIT_PERIOD/2-1 (integer divide): if rx_s==1, go to HDR with cnt<=0 and bit_cnt<=0; otherwise return to IDLE silently (glitch rejection).
- State HDR (seven 0 bits):
  - cnt increments and wraps to 0 at BIT_PERIOD-1.
  - Sample rx_s on the wrap cycle.
  - A sampled 1 gives header_error=1 for one cycle and a return to IDLE.
  - After the 7th sample (bit_cnt==6) with all samples 0: go to DATA with byte_cnt<=0 and bit_cnt<=0.
- State DATA:
  - Same sampling cadence as HDR.
  - Shift register: shreg <= {shreg[6:0], rx_s} on each sample.
  - On the 8th sample (bit_cnt==7):
    - data_out <= {shreg[6:0], rx_s} and data_valid=1 on the following cycle.
    - byte_cnt increments.
  - If byte_cnt==PAYLOAD_BYTES-1 at that sample: frame_done=1 in the same cycle as data_valid, then go to IDLE.
- Latency:
  - Marker rising edge on rx_in to MARK entry: 3 clocks.
  - Each later sample falls at mid-bit: BIT_PERIOD/2 + k·BIT_PERIOD clocks after the detected edge.
- Edges in HDR/DATA are ignored. There is no resynchronization inside a frame; the transmitter is crystal-locked to the same rate.
- A new frame can only start from IDLE. A rising edge in the cycle that leaves DATA is not captured; it is missed.
- busy=1 in MARK, HDR and DATA. It drops the cycle after frame_done, header_error, a glitch rejection, or enable low.
- Counter widths cover the maximum parameter values. No overflow is possible since cnt is always bounded by BIT_PERIOD-1.

Test Plan:
1. Nominal frame: reset 5 cycles, enable=1, BIT_PERIOD=50, PAYLOAD_BYTES=2; drive 0x80, 0xA5, 0x3C at 50 clk/bit.
   - Expect data_valid twice, data_out 0xA5 then 0x3C.
   - frame_done coincident with 0x3C.
   - busy low 1 cycle later. header_error never asserted.
2. Glitch rejection: 10-clock high pulse on rx_in while IDLE.
   - Expect busy high for about 25 clocks, then low.
   - No strobes. Then a normal frame decodes correctly.
3. Bad header: drive 0x90 then payload.
   - Expect header_error pulse at the 4th bit's mid-point, busy low, no data_valid.
   - The following correct frame decodes normally.
4. Enable drop: deassert enable mid-way through the first payload byte.
   - Expect busy low next cycle, no data_valid or frame_done, data_out unchanged.
   - Reassert enable and send a full frame: it decodes.
5. Async reset mid-frame: pulse reset during DATA.
   - Expect all outputs 0 immediately (no clock needed) and state IDLE.
   - After release, the next frame decodes with first byte correct.
6. Full default frame: PAYLOAD_BYTES=49, marker 0x80 followed by 49 bytes of 0x00 (400-bit pattern).
   - Expect 49 data_valid pulses all with 0x00.
   - frame_done on the 49th; total 400·50 clocks from edge ±25.

Source files
------------

// File: rtl/data_rate_decoder_if.sv
// Serial receive link and decoded-byte outputs of the data-rate decoder.
interface data_rate_decoder_if;
    logic       enable;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_done;
    logic       header_error;
    logic       busy;

    modport master (
        output enable, rx_in,
        input  data_out, data_valid, frame_done, header_error, busy
    );

    modport slave (
        input  enable, rx_in,
        output data_out, data_valid, frame_done, header_error, busy
    );
endinterface

// File: rtl/data_rate_decoder.sv
// Mid-bit sampling frame decoder: 0x80 marker byte, then payload bytes MSB first.
module data_rate_decoder #(
    parameter int BIT_PERIOD    = 50,
    parameter int PAYLOAD_BYTES = 49
) (
    input logic                clock,
    input logic                reset,
    data_rate_decoder_if.slave bus
);
    localparam logic [15:0] HALF_LAST = 16'(BIT_PERIOD / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, MARK, HDR, DATA} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, rx_s_q, rx_d_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        herr_q, herr_d;
    logic        busy_q, busy_d;
    logic        rise, tick;

    assign rise = rx_s_q & ~rx_d_q;
    assign tick = (cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        herr_d     = 1'b0;
        if (!bus.enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MARK;
                        cnt_d   = '0;
                    end
                end
                MARK: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == HALF_LAST) begin
                        // a pulse gone by mid-bit is line noise, not a marker
                        state_d   = rx_s_q ? HDR : IDLE;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                    end
                end
                HDR: begin
                    cnt_d = tick ? '0 : cnt_q + 16'd1;
                    if (tick) begin
                        if (rx_s_q) begin
                            herr_d  = 1'b1;
                            state_d = IDLE;
                        end else if (bit_cnt_q == 3'd6) begin
                            state_d    = DATA;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                DATA: begin
                    cnt_d = tick ? '0 : cnt_q + 16'd1;
                    if (tick) begin
                        shreg_d   = {shreg_q[5:0], rx_s_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d     = {shreg_q, rx_s_q};
                            valid_d    = 1'b1;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            if (byte_cnt_q == BYTE_LAST) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
            endcase
        end
        // stay busy through the closing strobe so it drops one cycle later
        busy_d = (state_d != IDLE) | done_d | herr_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            rx_s_q     <= 1'b0;
            rx_d_q     <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            herr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= bus.rx_in;
            rx_s_q     <= sync1_q;
            rx_d_q     <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            herr_q     <= herr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.frame_done   = done_q;
    assign bus.header_error = herr_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_data_rate_decoder.sv
// Bench for data_rate_decoder: short-frame (2 bytes) and full-frame (49 bytes) instances.
module tb_data_rate_decoder;
    localparam int BP = 50;
    localparam int HB = BP / 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_rate_decoder_if bs ();
    data_rate_decoder_if bf ();

    data_rate_decoder #(.BIT_PERIOD(BP), .PAYLOAD_BYTES(2)) u_small (
        .clock(clock), .reset(reset), .bus(bs)
    );
    data_rate_decoder #(.BIT_PERIOD(BP), .PAYLOAD_BYTES(49)) u_full (
        .clock(clock), .reset(reset), .bus(bf)
    );

    // event log of both instances, sampled on the falling edge
    logic [7:0] got_s[$];
    logic [7:0] got_f[$];
    int   fd_s = 0, fdv_s = 0, he_s = 0, fdcyc_s = 0, hecyc_s = 0;
    int   bfall_s = 0, bhigh_s = 0;
    logic bprev_s = 1'b0;
    int   fd_f = 0, fdv_f = 0, fdcyc_f = 0;

    always @(negedge clock) begin
        if (bs.data_valid) got_s.push_back(bs.data_out);
        if (bs.frame_done) begin
            fd_s    <= fd_s + 1;
            fdcyc_s <= cyc;
        end
        if (bs.frame_done && bs.data_valid) fdv_s <= fdv_s + 1;
        if (bs.header_error) begin
            he_s    <= he_s + 1;
            hecyc_s <= cyc;
        end
        if (bs.busy) bhigh_s <= bhigh_s + 1;
        if (bprev_s && !bs.busy) bfall_s <= cyc;
        bprev_s <= bs.busy;
        if (bf.data_valid) got_f.push_back(bf.data_out);
        if (bf.frame_done) begin
            fd_f    <= fd_f + 1;
            fdcyc_f <= cyc;
        end
        if (bf.frame_done && bf.data_valid) fdv_f <= fdv_f + 1;
    end

    // reference timing: strobe for frame bit i appears this many cycles after its edge
    function automatic int strobe_at(input int bit_idx);
        return 3 + HB + bit_idx * BP;
    endfunction

    logic [7:0] tx_q[$];

    task automatic send_bit(input bit full, input logic b);
        if (full) bf.rx_in = b;
        else bs.rx_in = b;
        repeat (BP) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input bit full, input logic [7:0] v, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) send_bit(full, v[i]);
    endtask

    task automatic send_frame(input bit full, input logic [7:0] marker, output int t0);
        t0 = cyc;
        send_byte(full, marker, 8);
        foreach (tx_q[i]) send_byte(full, tx_q[i], 8);
        send_bit(full, 1'b0);
    endtask

    task automatic rand_payload();
        tx_q = {};
        repeat (2) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // sends tx_q behind a good marker on the short instance and checks the outcome
    task automatic run_frame_s(input string tag);
        int t0, gb, fb, fvb, hb, nbad, ngot;
        gb = got_s.size(); fb = fd_s; fvb = fdv_s; hb = he_s;
        send_frame(1'b0, 8'h80, t0);
        ngot = got_s.size() - gb;
        n_chk++;
        if (ngot !== tx_q.size())
            $display("FAIL %s byte count: got %0d want %0d", tag, ngot, tx_q.size());
        else n_pass++;
        nbad = 0;
        foreach (tx_q[i])
            if (gb + i >= got_s.size() || got_s[gb + i] !== tx_q[i]) nbad++;
        n_chk++;
        if (nbad !== 0)
            $display("FAIL %s bytes: %0d wrong, want 0", tag, nbad);
        else n_pass++;
        n_chk++;
        if (fd_s - fb !== 1 || fdv_s - fvb !== 1)
            $display("FAIL %s frame_done: got %0d (%0d with valid) want 1", tag, fd_s - fb, fdv_s - fvb);
        else n_pass++;
        n_chk++;
        if (fdcyc_s !== t0 + strobe_at(8 * tx_q.size() + 7))
            $display("FAIL %s done cycle: got %0d want %0d", tag, fdcyc_s - t0, strobe_at(8 * tx_q.size() + 7));
        else n_pass++;
        n_chk++;
        if (bfall_s !== fdcyc_s + 1)
            $display("FAIL %s busy fall: got %0d want %0d", tag, bfall_s, fdcyc_s + 1);
        else n_pass++;
        n_chk++;
        if (he_s !== hb || bs.data_out !== tx_q[tx_q.size() - 1])
            $display("FAIL %s hdr_err/hold: got %0d/%h want 0/%h", tag, he_s - hb, bs.data_out, tx_q[tx_q.size() - 1]);
        else n_pass++;
    endtask

    task automatic test_reset();
        bs.enable = 1'b1; bs.rx_in = 1'b0;
        bf.enable = 1'b0; bf.rx_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_chk++;
        if ({bs.data_out, bs.data_valid, bs.frame_done, bs.header_error, bs.busy} !== 12'h0)
            $display("FAIL reset outputs: got %h want 0", {bs.data_out, bs.data_valid, bs.frame_done, bs.header_error, bs.busy});
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_chk++;
        if (bs.busy !== 1'b0 || bs.data_out !== 8'h00)
            $display("FAIL post-reset idle: got busy=%b data=%h want 0/00", bs.busy, bs.data_out);
        else n_pass++;
    endtask

    task automatic test_nominal();
        tx_q = {8'hA5, 8'h3C};
        run_frame_s("nominal");
        rand_payload();
        run_frame_s("nominal_rand");
    endtask

    task automatic test_glitch();
        int gb, hb, fb, bh, len;
        len = $urandom_range(4, 20);
        gb = got_s.size(); hb = he_s; fb = fd_s; bh = bhigh_s;
        bs.rx_in = 1'b1;
        repeat (len) @(posedge clock);
        #1;
        bs.rx_in = 1'b0;
        repeat (2 * BP) @(posedge clock);
        #1;
        n_chk++;
        if (bhigh_s - bh !== HB)
            $display("FAIL glitch busy: got %0d cycles want %0d", bhigh_s - bh, HB);
        else n_pass++;
        n_chk++;
        if (got_s.size() - gb !== 0 || he_s - hb !== 0 || fd_s - fb !== 0)
            $display("FAIL glitch strobes: got %0d/%0d/%0d want 0/0/0", got_s.size() - gb, he_s - hb, fd_s - fb);
        else n_pass++;
        rand_payload();
        run_frame_s("after_glitch");
    endtask

    task automatic test_bad_header();
        for (int r = 0; r < 2; r++) begin
            int k, t0, gb, hb, fb;
            logic [7:0] m;
            k = (r == 0) ? 3 : $urandom_range(1, 7);
            m = 8'h80 | (8'h80 >> k);
            tx_q = {8'h00, 8'h00};
            gb = got_s.size(); hb = he_s; fb = fd_s;
            send_frame(1'b0, m, t0);
            n_chk++;
            if (he_s - hb !== 1 || hecyc_s !== t0 + strobe_at(k))
                $display("FAIL bad_hdr %h: got %0d at %0d want 1 at %0d", m, he_s - hb, hecyc_s - t0, strobe_at(k));
            else n_pass++;
            n_chk++;
            if (got_s.size() - gb !== 0 || fd_s - fb !== 0 || bfall_s !== hecyc_s + 1)
                $display("FAIL bad_hdr %h aftermath: got %0d valid %0d done fall %0d want 0 0 %0d", m, got_s.size() - gb, fd_s - fb, bfall_s, hecyc_s + 1);
            else n_pass++;
            rand_payload();
            run_frame_s("after_bad_hdr");
        end
    endtask

    task automatic test_enable_drop();
        int gb, fb;
        logic [7:0] keep;
        keep = bs.data_out;
        gb = got_s.size(); fb = fd_s;
        send_byte(1'b0, 8'h80, 8);
        send_byte(1'b0, 8'($urandom_range(0, 255)), 4);
        bs.enable = 1'b0;
        @(posedge clock);
        #1;
        n_chk++;
        if (bs.busy !== 1'b0)
            $display("FAIL enable_drop busy: got %b want 0", bs.busy);
        else n_pass++;
        bs.rx_in = 1'b0;
        repeat (3 * BP) @(posedge clock);
        #1;
        n_chk++;
        if (got_s.size() - gb !== 0 || fd_s - fb !== 0 || bs.data_out !== keep)
            $display("FAIL enable_drop: got %0d valid %0d done data %h want 0 0 %h", got_s.size() - gb, fd_s - fb, bs.data_out, keep);
        else n_pass++;
        bs.enable = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rand_payload();
        run_frame_s("after_enable");
    endtask

    task automatic test_async_reset();
        rand_payload();
        send_byte(1'b0, 8'h80, 8);
        send_byte(1'b0, tx_q[0], 8);
        send_byte(1'b0, tx_q[1], 3);
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({bs.data_out, bs.data_valid, bs.frame_done, bs.header_error, bs.busy} !== 12'h0)
            $display("FAIL async reset: got %h want 0", {bs.data_out, bs.data_valid, bs.frame_done, bs.header_error, bs.busy});
        else n_pass++;
        bs.rx_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (BP) @(posedge clock);
        #1;
        n_chk++;
        if (bs.busy !== 1'b0)
            $display("FAIL after reset busy: got %b want 0", bs.busy);
        else n_pass++;
        rand_payload();
        run_frame_s("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            run_frame_s("back_to_back");
        end
    endtask

    task automatic test_full_frame();
        int t0, gb, fb, fvb, nz;
        bf.enable = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        tx_q = {};
        repeat (49) tx_q.push_back(8'h00);
        gb = got_f.size(); fb = fd_f; fvb = fdv_f;
        send_frame(1'b1, 8'h80, t0);
        n_chk++;
        if (got_f.size() - gb !== 49)
            $display("FAIL full count: got %0d want 49", got_f.size() - gb);
        else n_pass++;
        nz = 0;
        for (int i = gb; i < got_f.size(); i++) if (got_f[i] !== 8'h00) nz++;
        n_chk++;
        if (nz !== 0)
            $display("FAIL full bytes: got %0d nonzero want 0", nz);
        else n_pass++;
        n_chk++;
        if (fd_f - fb !== 1 || fdv_f - fvb !== 1)
            $display("FAIL full done: got %0d (%0d with valid) want 1", fd_f - fb, fdv_f - fvb);
        else n_pass++;
        n_chk++;
        if (fdcyc_f !== t0 + strobe_at(399))
            $display("FAIL full done cycle: got %0d want %0d", fdcyc_f - t0, strobe_at(399));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_bad_header();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        test_full_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
